// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount greedily from five coin tubes,
// one ejection per slot, tracking tube inventory and reporting any shortfall.
module change_dispenser #(
    parameter int INIT_COUNT = 8,
    parameter int COUNT_W    = 8,
    parameter int COIN_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] change_in,
    input  logic [7:0] refill_in,
    output logic [7:0] coin_out,
    output logic       coin_valid,
    output logic       busy,
    output logic [7:0] short_out,
    output logic       short_err,
    output logic [4:0] tube_empty
);

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        GAP,
        WAIT_CLR
    } state_t;

    localparam int NUM_TUBES = 5;
    localparam int GAP_W     = (COIN_GAP < 2) ? 1 : $clog2(COIN_GAP + 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_W-1:0] CNT_INIT = COUNT_W'(INIT_COUNT);

    // Tube index 0..4 holds 10, 20, 50, 100, 200 cents.
    function automatic logic [7:0] denom(input int idx);
        case (idx)
            0:       return 8'd10;
            1:       return 8'd20;
            2:       return 8'd50;
            3:       return 8'd100;
            default: return 8'd200;
        endcase
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [7:0]         remaining;
    logic [COUNT_W-1:0] tube_cnt [NUM_TUBES];

    logic               refill_hit;
    logic [2:0]         refill_idx;
    logic               sel_found;
    logic [2:0]         sel_idx;
    logic [7:0]         sel_coin;
    logic [7:0]         rem_after;
    logic               dispense_now;
    logic [NUM_TUBES-1:0] tube_inc;
    logic [NUM_TUBES-1:0] tube_dec;

    always_comb begin
        refill_hit = 1'b1;
        refill_idx = 3'd0;
        case (refill_in)
            8'd10:   refill_idx = 3'd0;
            8'd20:   refill_idx = 3'd1;
            8'd50:   refill_idx = 3'd2;
            8'd100:  refill_idx = 3'd3;
            8'd200:  refill_idx = 3'd4;
            default: refill_hit = 1'b0;
        endcase
    end

    // Greedy pick: largest stocked denomination that still fits.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        for (int i = NUM_TUBES - 1; i >= 0; i--) begin
            if (!sel_found && tube_cnt[i] != '0 && denom(i) <= remaining) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
            end
        end
    end

    assign sel_coin     = denom(int'(sel_idx));
    assign rem_after    = remaining - sel_coin;
    assign dispense_now = (state == DISPENSE) && sel_found;

    always_comb begin
        tube_inc = '0;
        tube_dec = '0;
        for (int i = 0; i < NUM_TUBES; i++) begin
            tube_inc[i] = refill_hit && (refill_idx == 3'(i));
            tube_dec[i] = dispense_now && (sel_idx == 3'(i));
        end
    end

    // A simultaneous refill and ejection on one tube cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TUBES; i++) begin
                tube_cnt[i] <= CNT_INIT;
            end
            tube_empty <= '0;
        end else begin
            for (int i = 0; i < NUM_TUBES; i++) begin
                if (tube_inc[i] && !tube_dec[i]) begin
                    tube_cnt[i] <= sat_inc(tube_cnt[i]);
                end else if (tube_dec[i] && !tube_inc[i]) begin
                    tube_cnt[i] <= tube_cnt[i] - 1'b1;
                end
                tube_empty[i] <= (tube_cnt[i] == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && change_in != 8'd0) begin
            remaining <= change_in;
        end else if (dispense_now) begin
            remaining <= rem_after;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            coin_out   <= 8'd0;
            coin_valid <= 1'b0;
            busy       <= 1'b0;
            short_out  <= 8'd0;
            short_err  <= 1'b0;
        end else begin
            coin_out   <= 8'd0;
            coin_valid <= 1'b0;
            short_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (change_in != 8'd0) begin
                        short_out <= 8'd0;
                        busy      <= 1'b1;
                        state     <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (sel_found) begin
                        coin_out   <= sel_coin;
                        coin_valid <= 1'b1;
                        if (rem_after == 8'd0) begin
                            state <= WAIT_CLR;
                        end else if (COIN_GAP == 0) begin
                            state <= DISPENSE;
                        end else begin
                            gap_cnt <= GAP_W'(COIN_GAP - 1);
                            state   <= GAP;
                        end
                    end else begin
                        short_out <= remaining;
                        short_err <= 1'b1;
                        state     <= WAIT_CLR;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= DISPENSE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                WAIT_CLR: begin
                    // Hold off until the source drops its request so it is paid once.
                    if (change_in == 8'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed scenarios plus randomized requests
// checked against a greedy tube-inventory model.
module tb_change_dispenser;

    localparam int G    = 1;
    localparam int INIT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] change_in = 8'd0;
    logic [7:0] refill_in = 8'd0;
    logic [7:0] coin_out;
    logic       coin_valid;
    logic       busy;
    logic [7:0] short_out;
    logic       short_err;
    logic [4:0] tube_empty;

    int checks = 0;
    int errors = 0;
    int cnt [5];
    int den [5] = '{10, 20, 50, 100, 200};
    int exp_coins [$];

    change_dispenser #(.INIT_COUNT(INIT), .COUNT_W(8), .COIN_GAP(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .change_in  (change_in),
        .refill_in  (refill_in),
        .coin_out   (coin_out),
        .coin_valid (coin_valid),
        .busy       (busy),
        .short_out  (short_out),
        .short_err  (short_err),
        .tube_empty (tube_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Greedy payout: exhaust each denomination from largest down; returns the unpaid rest.
    function automatic int model_pay(input int amount);
        int amt;
        amt = amount;
        exp_coins.delete();
        for (int i = 4; i >= 0; i--) begin
            while (amt >= den[i] && cnt[i] > 0) begin
                exp_coins.push_back(den[i]);
                cnt[i] = cnt[i] - 1;
                amt = amt - den[i];
            end
        end
        return amt;
    endfunction

    function automatic void model_refill(input int v);
        for (int i = 0; i < 5; i++) begin
            if (v == den[i] && cnt[i] < 255) cnt[i] = cnt[i] + 1;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) cnt[i] = INIT;
    endfunction

    task automatic idle_refill(input int v);
        @(negedge clk);
        refill_in = 8'(v);
        model_refill(v);
        @(negedge clk);
        refill_in = 8'd0;
    endtask

    task automatic do_request(input int amt, input int hold, input int rf_edge, input int rf_val);
        int n, sh, last, win, exp_v, t;
        logic exp_se;
        sh = model_pay(amt);
        n = exp_coins.size();
        if (rf_edge >= 0) model_refill(rf_val);
        last = (sh != 0) ? 1 + n * (G + 1) : 1 + (n - 1) * (G + 1);
        win = ((last > hold) ? last : hold) + 3;
        @(negedge clk);
        change_in = 8'(amt);
        for (int e = 0; e <= win; e++) begin
            if (e == hold) change_in = 8'd0;
            if (e == rf_edge) refill_in = 8'(rf_val);
            @(posedge clk);
            #1;
            refill_in = 8'd0;
            exp_v = 0;
            for (int k = 0; k < n; k++) begin
                if (e == 1 + k * (G + 1)) exp_v = exp_coins[k];
            end
            exp_se = (sh != 0) && (e == last);
            checks++;
            if (coin_out !== 8'(exp_v) || coin_valid !== (exp_v != 0)) begin
                errors++;
                $display("FAIL coin amt=%0d edge=%0d: got %0d valid=%0b, want %0d", amt, e, coin_out, coin_valid, exp_v);
            end
            checks++;
            if (short_err !== exp_se) begin
                errors++;
                $display("FAIL short_err amt=%0d edge=%0d: got %0b, want %0b", amt, e, short_err, exp_se);
            end
            if (e <= last) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy amt=%0d edge=%0d: got %0b, want 1", amt, e, busy);
                end
            end
            if (e == 0) begin
                checks++;
                if (short_out !== 8'd0) begin
                    errors++;
                    $display("FAIL short_clear amt=%0d: got %0d, want 0", amt, short_out);
                end
            end
        end
        t = 0;
        while (busy === 1'b1 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_release amt=%0d: got %0b, want 0", amt, busy);
        end
        checks++;
        if (short_out !== 8'(sh)) begin
            errors++;
            $display("FAIL short_out amt=%0d: got %0d, want %0d", amt, short_out, sh);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut.tube_cnt[i] !== 8'(cnt[i]) || tube_empty[i] !== (cnt[i] == 0)) begin
                errors++;
                $display("FAIL tube%0d amt=%0d: got cnt=%0d empty=%0b, want cnt=%0d empty=%0b",
                         den[i], amt, dut.tube_cnt[i], tube_empty[i], cnt[i], cnt[i] == 0);
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (coin_out !== 8'd0 || coin_valid !== 1'b0 || busy !== 1'b0 ||
            short_out !== 8'd0 || short_err !== 1'b0 || tube_empty !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: got coin=%0d v=%0b busy=%0b short=%0d err=%0b empty=%b, want all 0",
                     coin_out, coin_valid, busy, short_out, short_err, tube_empty);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut.tube_cnt[i] !== 8'(INIT)) begin
                errors++;
                $display("FAIL reset_tube%0d: got %0d, want %0d", den[i], dut.tube_cnt[i], INIT);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_request(150, 2, -1, 0);
        do_request(200, 1, -1, 0);
        do_request(30, 1, -1, 0);
    endtask

    task automatic test_shortfall();
        while (cnt[0] > 0) do_request(10, 1, -1, 0);
        do_request(30, 1, -1, 0);
        idle_refill(10);
        do_request(15, 1, -1, 0);
    endtask

    task automatic test_refill();
        idle_refill(30);
        idle_refill(0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut.tube_cnt[i] !== 8'(cnt[i])) begin
                errors++;
                $display("FAIL invalid_refill tube%0d: got %0d, want %0d", den[i], dut.tube_cnt[i], cnt[i]);
            end
        end
        // 10 tube is empty here: a refill at the decision edge must not be paid from.
        do_request(10, 1, 1, 10);
        do_request(10, 1, 1, 10);
    endtask

    task automatic test_hold();
        do_request(20, 8, -1, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        change_in = 8'd150;
        @(posedge clk);
        @(negedge clk);
        change_in = 8'd0;
        @(posedge clk);
        #1;
        checks++;
        if (coin_out !== 8'd100) begin
            errors++;
            $display("FAIL mid_first_coin: got %0d, want 100", coin_out);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (coin_out !== 8'd0 || coin_valid !== 1'b0 || busy !== 1'b0 || short_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got coin=%0d v=%0b busy=%0b err=%0b, want 0",
                     coin_out, coin_valid, busy, short_err);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut.tube_cnt[i] !== 8'(INIT)) begin
                errors++;
                $display("FAIL mid_reset_tube%0d: got %0d, want %0d", den[i], dut.tube_cnt[i], INIT);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        do_request(150, 2, -1, 0);
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 252; k++) idle_refill(200);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut.tube_cnt[4] !== 8'(cnt[4]) || cnt[4] != 255) begin
            errors++;
            $display("FAIL saturate: got %0d, want 255 (model %0d)", dut.tube_cnt[4], cnt[4]);
        end
    endtask

    task automatic test_random();
        int vals [9] = '{0, 10, 20, 50, 100, 200, 30, 5, 255};
        for (int it = 0; it < 25; it++) begin
            for (int r = 0; r < int'($urandom_range(0, 3)); r++) begin
                idle_refill(vals[$urandom_range(0, 8)]);
            end
            do_request(int'($urandom_range(1, 255)), int'($urandom_range(1, 4)), -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shortfall();
        test_refill();
        test_hold();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
